icache_refill_ctlr: RTL and testbench

ICACHE_REFILL_CTLR -- requirements
Module: icache_refill_ctlr

---
 rtl/icache_refill_ctlr.sv | 178 +++++++++++++++++
 tb/tb_icache_refill_ctlr.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctlr.sv
// I-cache line refill controller: hit detect, victim pick,
// memory request/grant, word-by-word fill and per-set round-robin.
module icache_refill_ctlr #(
  parameter int S = 64,
  parameter int E = 2,
  parameter int B = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [$clog2(S)-1:0] set_i,
  input  logic [E-1:0]         way_hit_i,
  input  logic [E-1:0]         way_valid_i,
  input  logic [1:0]           pc_src_reg_i,
  input  logic [1:0]           branch_op_e_i,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  output logic [S-1:0]         active_array_o,
  output logic                 instr_hit_f_o,
  output logic [$clog2(E)-1:0] hit_way_o,
  output logic                 mem_req_o,
  output logic                 fill_we_o,
  output logic [E-1:0]         fill_way_o,
  output logic [$clog2(B)-1:0] fill_word_o,
  output logic                 fill_done_o,
  output logic                 stall_f_o
);

  localparam int SW = $clog2(S);
  localparam int WW = $clog2(E);
  localparam int BW = $clog2(B);
  localparam logic [1:0] NON_BRANCH = 2'b00;

  typedef enum logic [2:0] {
    IDLE, WAIT, REQ, FILL, DONE
  } state_t;

  state_t          state_q;
  state_t          nxt;
  state_t          st;
  logic [SW-1:0]   set_q;
  logic [WW-1:0]   way_q;
  logic [BW-1:0]   cnt_q;
  logic [WW-1:0]   rr_q [S];
  logic [WW-1:0]   victim;
  logic [WW-1:0]   hit_way;
  logic            latch;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            rr_adv;
  logic            miss;
  logic            redir;

  assign miss  = ~|way_hit_i;
  assign redir = pc_src_reg_i[1];

  // Victim: lowest invalid way, else the set's round-robin pointer
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = rr_q[set_i];
    for (int i = 0; i < E; i++) begin
      if (!way_valid_i[i] && !found) begin
        victim = WW'(i);
        found  = 1'b1;
      end
    end
  end

  // Priority-encode the lowest hitting way
  always_comb begin
    logic found;
    found   = 1'b0;
    hit_way = '0;
    for (int i = 0; i < E; i++) begin
      if (way_hit_i[i] && !found) begin
        hit_way = WW'(i);
        found   = 1'b1;
      end
    end
  end

  assign hit_way_o   = hit_way;
  assign fill_word_o = cnt_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= nxt;
  end

  // Next state and outputs; reset makes outputs look like IDLE
  always_comb begin
    st             = reset_i ? IDLE : state_q;
    nxt            = state_q;
    latch          = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    rr_adv         = 1'b0;
    mem_req_o      = 1'b0;
    fill_we_o      = 1'b0;
    fill_way_o     = '0;
    fill_done_o    = 1'b0;
    instr_hit_f_o  = 1'b0;
    stall_f_o      = 1'b0;
    active_array_o = S'(1) << set_i;
    case (st)
      IDLE: begin
        instr_hit_f_o = ~miss;
        stall_f_o     = miss & ~redir;
        if (miss && !redir) begin
          latch = 1'b1;
          nxt   = (branch_op_e_i != NON_BRANCH) ? WAIT : REQ;
        end
      end
      WAIT: begin
        instr_hit_f_o = ~miss;
        stall_f_o     = miss & ~redir;
        if (redir || !miss) begin
          nxt = IDLE;
        end else begin
          latch = 1'b1;
          nxt   = REQ;
        end
      end
      REQ: begin
        mem_req_o      = 1'b1;
        stall_f_o      = 1'b1;
        active_array_o = S'(1) << set_q;
        if (mem_gnt_i) begin
          cnt_clr = 1'b1;
          nxt     = FILL;
        end else if (redir) begin
          nxt = IDLE;
        end
      end
      FILL: begin
        stall_f_o      = 1'b1;
        active_array_o = S'(1) << set_q;
        fill_way_o     = E'(1) << way_q;
        fill_we_o      = mem_rvalid_i;
        if (mem_rvalid_i) begin
          cnt_inc = 1'b1;
          if (cnt_q == BW'(B - 1)) nxt = DONE;
        end
      end
      DONE: begin
        stall_f_o      = 1'b1;
        fill_done_o    = 1'b1;
        active_array_o = S'(1) << set_q;
        rr_adv         = (way_q == rr_q[set_q]);
        nxt            = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Latched miss context, word counter and round-robin pointers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      set_q <= '0;
      way_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < S; i++) rr_q[i] <= '0;
    end else begin
      if (latch) begin
        set_q <= set_i;
        way_q <= victim;
      end
      if (cnt_clr) cnt_q <= '0;
      else if (cnt_inc)
        cnt_q <= (cnt_q == BW'(B - 1)) ? '0 : cnt_q + BW'(1);
      if (rr_adv)
        rr_q[set_q] <= (rr_q[set_q] == WW'(E - 1)) ?
                       '0 : rr_q[set_q] + WW'(1);
    end
  end

endmodule

// File: tb/tb_icache_refill_ctlr.sv
// Directed vector bench for icache_refill_ctlr (S=64, E=2, B=4).
// Each vector is one clock: drive after posedge, check at negedge.
module tb_icache_refill_ctlr;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [5:0]  set_i;
  logic [1:0]  way_hit_i;
  logic [1:0]  way_valid_i;
  logic [1:0]  pc_src_reg_i;
  logic [1:0]  branch_op_e_i;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] active_array_o;
  logic        instr_hit_f_o;
  logic        hit_way_o;
  logic        mem_req_o;
  logic        fill_we_o;
  logic [1:0]  fill_way_o;
  logic [1:0]  fill_word_o;
  logic        fill_done_o;
  logic        stall_f_o;

  icache_refill_ctlr #(.S(64), .E(2), .B(4)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .set_i          (set_i),
    .way_hit_i      (way_hit_i),
    .way_valid_i    (way_valid_i),
    .pc_src_reg_i   (pc_src_reg_i),
    .branch_op_e_i  (branch_op_e_i),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .active_array_o (active_array_o),
    .instr_hit_f_o  (instr_hit_f_o),
    .hit_way_o      (hit_way_o),
    .mem_req_o      (mem_req_o),
    .fill_we_o      (fill_we_o),
    .fill_way_o     (fill_way_o),
    .fill_word_o    (fill_word_o),
    .fill_done_o    (fill_done_o),
    .stall_f_o      (stall_f_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      nm;
    logic       rst;
    int         set;
    logic [1:0] hit, val, pcs, bop;
    logic       gnt, rv;
    int         aset;
    logic       ih, hw, req, we;
    logic [1:0] fw, wd;
    logic       dn, st;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    string nm, logic rst, int set, logic [1:0] hit, logic [1:0] val,
    logic [1:0] pcs, logic [1:0] bop, logic gnt, logic rv,
    int aset, logic ih, logic hw, logic req, logic we,
    logic [1:0] fw, logic [1:0] wd, logic dn, logic st);
    vec_t v;
    v.nm = nm; v.rst = rst; v.set = set; v.hit = hit; v.val = val;
    v.pcs = pcs; v.bop = bop; v.gnt = gnt; v.rv = rv;
    v.aset = aset; v.ih = ih; v.hw = hw; v.req = req; v.we = we;
    v.fw = fw; v.wd = wd; v.dn = dn; v.st = st;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset_i       = v.rst;
    set_i         = 6'(v.set);
    way_hit_i     = v.hit;
    way_valid_i   = v.val;
    pc_src_reg_i  = v.pcs;
    branch_op_e_i = v.bop;
    mem_gnt_i     = v.gnt;
    mem_rvalid_i  = v.rv;
  endtask

  task automatic run(input vec_t v);
    logic [73:0] act, exp;
    logic [63:0] ea;
    drive(v);
    @(negedge clk_i);
    ea  = 64'(1) << v.aset;
    exp = {ea, v.ih, v.hw, v.req, v.we, v.fw, v.wd, v.dn, v.st};
    act = {active_array_o, instr_hit_f_o, hit_way_o, mem_req_o,
           fill_we_o, fill_way_o, fill_word_o, fill_done_o, stall_f_o};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", v.nm, act, exp);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int   cyc;
    logic seen;
    //          name    rst set hit  val  pcs  bop  g  rv aset ih hw rq we fw  wd  dn st
    tbl.push_back(mk("rst_miss", 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("rst_hit",  1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("hit_w1",   0, 3, 2'b10, 2'b11, 0, 0, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("hit_both", 0, 3, 2'b11, 2'b11, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("miss5",    0, 5, 2'b00, 2'b11, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("req_nog",  0, 9, 2'b00, 2'b11, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("req_gnt",  0, 9, 2'b00, 2'b11, 0, 0, 1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("fill_w0",  0, 9, 2'b00, 2'b11, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk("fill_gap", 0, 9, 2'b00, 2'b11, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk("fill_w1",  0, 9, 2'b00, 2'b11, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk("fill_w2",  0, 9, 2'b00, 2'b11, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 2, 0, 1));
    tbl.push_back(mk("fill_w3",  0, 9, 2'b00, 2'b11, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 3, 0, 1));
    tbl.push_back(mk("done5",    0, 9, 2'b00, 2'b11, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("idle_rdr", 0, 5, 2'b00, 2'b11, 2, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("inv_miss", 0, 5, 2'b00, 2'b10, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("inv_gnt",  0, 5, 2'b00, 2'b10, 0, 0, 1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("inv_w0",   0, 5, 2'b00, 2'b10, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk("inv_w1",   0, 5, 2'b00, 2'b10, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk("inv_w2",   0, 5, 2'b00, 2'b10, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 2, 0, 1));
    tbl.push_back(mk("inv_w3",   0, 5, 2'b00, 2'b10, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 3, 0, 1));
    tbl.push_back(mk("inv_done", 0, 5, 2'b00, 2'b10, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("rr_miss",  0, 5, 2'b00, 2'b11, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gnt_rdr",  0, 5, 2'b00, 2'b11, 2, 0, 1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("rr_w0",    0, 5, 2'b00, 2'b11, 2, 0, 0, 1, 5, 0, 0, 0, 1, 2, 0, 0, 1));
    tbl.push_back(mk("rdr_w1",   0, 5, 2'b00, 2'b11, 2, 0, 0, 1, 5, 0, 0, 0, 1, 2, 1, 0, 1));
    tbl.push_back(mk("rdr_w2",   0, 5, 2'b00, 2'b11, 2, 0, 0, 1, 5, 0, 0, 0, 1, 2, 2, 0, 1));
    tbl.push_back(mk("rdr_w3",   0, 5, 2'b00, 2'b11, 0, 0, 0, 1, 5, 0, 0, 0, 1, 2, 3, 0, 1));
    tbl.push_back(mk("rdr_done", 0, 5, 2'b00, 2'b11, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("br_miss",  0, 7, 2'b00, 2'b11, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("wait_rdr", 0, 7, 2'b00, 2'b11, 2, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("br_miss2", 0, 7, 2'b00, 2'b11, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("wait_hit", 0, 7, 2'b01, 2'b11, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("br_miss3", 0, 7, 2'b00, 2'b11, 0, 2, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("wait_req", 0, 8, 2'b00, 2'b01, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("req_rdr",  0, 3, 2'b00, 2'b11, 2, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("idle_back",0, 8, 2'b10, 2'b11, 0, 0, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0));

    reset_i = 1'b1;
    drive(tbl[0]);
    repeat (2) @(posedge clk_i);
    #1;
    foreach (tbl[i]) run(tbl[i]);

    // Full fill of set 12 with bounded wait for the done pulse
    run(mk("s12_miss", 0, 12, 2'b00, 2'b11, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 1));
    run(mk("s12_gnt",  0, 12, 2'b00, 2'b11, 0, 0, 1, 0, 12, 0, 0, 1, 0, 0, 0, 0, 1));
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk_i);
      cyc++;
      if (fill_done_o) seen = 1'b1;
      @(posedge clk_i);
      #1;
    end
    mem_rvalid_i = 1'b0;
    n_vec++;
    if (!seen || cyc != 5) begin
      n_fail++;
      $display("FAIL s12_done_wait: seen=%0b cycles=%0d want seen=1 cycles=5",
               seen, cyc);
    end

    // Reset at word 2 of the second set-12 fill (victim way1 from rr)
    run(mk("s12_miss2", 0, 12, 2'b00, 2'b11, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 1));
    run(mk("s12_gnt2",  0, 12, 2'b00, 2'b11, 0, 0, 1, 0, 12, 0, 0, 1, 0, 0, 0, 0, 1));
    run(mk("s12_w0",    0, 12, 2'b00, 2'b11, 0, 0, 0, 1, 12, 0, 0, 0, 1, 2, 0, 0, 1));
    run(mk("s12_w1",    0, 12, 2'b00, 2'b11, 0, 0, 0, 1, 12, 0, 0, 0, 1, 2, 1, 0, 1));
    run(mk("rst_w2",    1, 12, 2'b00, 2'b11, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 2, 0, 1));
    run(mk("post_rst",  0, 12, 2'b00, 2'b11, 2, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0));
    // rr cleared by reset: set 12 picks way0 again
    run(mk("s12_miss3", 0, 12, 2'b00, 2'b11, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 1));
    run(mk("s12_gnt3",  0, 12, 2'b00, 2'b11, 0, 0, 1, 0, 12, 0, 0, 1, 0, 0, 0, 0, 1));
    run(mk("s12_rr0",   0, 12, 2'b00, 2'b11, 0, 0, 0, 1, 12, 0, 0, 0, 1, 1, 0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
